// File: rtl/cic_interp_var.sv
// Run-time rate CIC interpolator (R = 2^rate_log2) with unity-gain output scaling,
// round-half-up, saturation, bypass, and clock-enable backpressure towards upstream.
module cic_interp_var #(
    parameter int IN_WIDTH        = 18,
    parameter int OUT_WIDTH       = 16,
    parameter int STAGES          = 4,
    parameter int DIFF_DELAY_LOG2 = 0,
    parameter int MAX_RATE_LOG2   = 4,
    localparam int RATE_W = (MAX_RATE_LOG2 > 0) ? $clog2(MAX_RATE_LOG2 + 1) : 1,
    localparam int W_INT  = IN_WIDTH + (STAGES - 1) * MAX_RATE_LOG2 + STAGES * DIFF_DELAY_LOG2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_enable,
    input  logic [RATE_W-1:0]           rate_log2,
    input  logic                        bypass,
    input  logic signed [IN_WIDTH-1:0]  filter_in,
    output logic signed [OUT_WIDTH-1:0] filter_out,
    output logic                        ce_out
);

    localparam int M        = 1 << DIFF_DELAY_LOG2;
    localparam int PHASE_W  = (MAX_RATE_LOG2 > 0) ? MAX_RATE_LOG2 : 1;
    localparam int WS       = W_INT + 6;
    localparam int ALIGN_L  = (OUT_WIDTH > IN_WIDTH) ? OUT_WIDTH - IN_WIDTH : 0;
    localparam int ALIGN_R  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH - OUT_WIDTH : 0;
    localparam int SHIFT_W  = 8;

    localparam logic signed [WS-1:0] ALIGN_RND = WS'((1 << ALIGN_R) >> 1);
    localparam logic signed [WS-1:0] SAT_MAX   = WS'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WS-1:0] SAT_MIN   = WS'(-(1 << (OUT_WIDTH - 1)));

    logic [PHASE_W-1:0]         phase_q, phase_d;
    logic [RATE_W-1:0]          act_r_q, act_r_d;
    logic signed [W_INT-1:0]    comb_dly_q [STAGES][M];
    logic signed [W_INT-1:0]    comb_dly_d [STAGES][M];
    logic signed [W_INT-1:0]    u_q, u_d;
    logic signed [W_INT-1:0]    integ_q [STAGES];
    logic signed [W_INT-1:0]    integ_d [STAGES];
    logic signed [OUT_WIDTH-1:0] filter_out_q, filter_out_d;

    logic signed [W_INT-1:0]    comb_x [STAGES+1];
    logic [RATE_W-1:0]          rate_clamped;
    logic [PHASE_W-1:0]         rate_mask;
    logic                       phase_wrap;
    logic [SHIFT_W-1:0]         shift_amt;
    logic [WS-1:0]              scale_rnd;
    logic signed [WS-1:0]       scaled;

    // Align a value of input significance to the output width, then clip.
    function automatic logic signed [OUT_WIDTH-1:0] sat_align(input logic signed [WS-1:0] val);
        logic signed [WS-1:0] aligned;
        aligned = ((val + ALIGN_RND) >>> ALIGN_R) <<< ALIGN_L;
        if (aligned > SAT_MAX) begin
            aligned = SAT_MAX;
        end else if (aligned < SAT_MIN) begin
            aligned = SAT_MIN;
        end
        return signed'(aligned[OUT_WIDTH-1:0]);
    endfunction

    always_comb begin
        rate_clamped = (rate_log2 > RATE_W'(MAX_RATE_LOG2)) ? RATE_W'(MAX_RATE_LOG2) : rate_log2;
        rate_mask    = PHASE_W'((32'd1 << act_r_q) - 32'd1);
        phase_wrap   = (phase_q == rate_mask);
        ce_out       = clk_enable & ~reset & (bypass | phase_wrap);
    end

    // Comb section sits in front of the zero-stuffer, so it only sees low-rate samples.
    always_comb begin
        comb_x[0] = W_INT'(filter_in);
        for (int k = 0; k < STAGES; k++) begin
            comb_x[k+1] = comb_x[k] - comb_dly_q[k][M-1];
        end
    end

    // Gain of the active rate is R^(N-1) * M^N, a power of two, so normalising is a shift.
    always_comb begin
        shift_amt = SHIFT_W'(STAGES - 1) * SHIFT_W'(act_r_q) + SHIFT_W'(STAGES * DIFF_DELAY_LOG2);
        scale_rnd = (WS'(1) << shift_amt) >> 1;
        scaled    = (WS'(integ_q[STAGES-1]) + signed'(scale_rnd)) >>> shift_amt;
    end

    always_comb begin
        phase_d      = phase_q;
        act_r_d      = act_r_q;
        comb_dly_d   = comb_dly_q;
        u_d          = u_q;
        integ_d      = integ_q;
        filter_out_d = filter_out_q;

        if (clk_enable) begin
            if (bypass) begin
                phase_d = '0;
                act_r_d = rate_clamped;
                u_d     = '0;
                for (int k = 0; k < STAGES; k++) begin
                    integ_d[k] = '0;
                    for (int m = 0; m < M; m++) begin
                        comb_dly_d[k][m] = '0;
                    end
                end
                filter_out_d = sat_align(WS'(filter_in));
            end else begin
                if (phase_q == '0) begin
                    for (int k = 0; k < STAGES; k++) begin
                        comb_dly_d[k][0] = comb_x[k];
                        for (int m = 1; m < M; m++) begin
                            comb_dly_d[k][m] = comb_dly_q[k][m-1];
                        end
                    end
                    u_d = comb_x[STAGES];
                end else begin
                    u_d = '0;
                end

                integ_d[0] = integ_q[0] + u_q;
                for (int k = 1; k < STAGES; k++) begin
                    integ_d[k] = integ_q[k] + integ_q[k-1];
                end

                filter_out_d = sat_align(scaled);

                // A new rate only takes hold at the wrap, so the phase always restarts cleanly.
                if (phase_wrap) begin
                    phase_d = '0;
                    act_r_d = rate_clamped;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q      <= '0;
            act_r_q      <= rate_clamped;
            u_q          <= '0;
            filter_out_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
                for (int m = 0; m < M; m++) begin
                    comb_dly_q[k][m] <= '0;
                end
            end
        end else begin
            phase_q      <= phase_d;
            act_r_q      <= act_r_d;
            u_q          <= u_d;
            filter_out_q <= filter_out_d;
            integ_q      <= integ_d;
            comb_dly_q   <= comb_dly_d;
        end
    end

    assign filter_out = filter_out_q;

endmodule

// File: tb/tb_cic_interp_var.sv
// Directed bench for cic_interp_var: 16-bit in/out, N=4, M=1, rates up to 2^4.
module tb_cic_interp_var;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_enable;
    logic [2:0]         rate_log2;
    logic               bypass;
    logic signed [15:0] filter_in;
    logic signed [15:0] filter_out;
    logic               ce_out;

    int   checks = 0;
    int   errors = 0;
    logic last_ce;

    typedef struct {
        logic               en;
        logic signed [15:0] din;
        int                 exp_out;
        logic               exp_ce;
    } vec_t;

    vec_t imp_tab [13];

    // DC 1000 at R=8: first outputs are round(1000 * C(n+3,3) / 512) after a 5-enable latency.
    int step_exp [13] = '{0, 0, 0, 0, 0, 2, 8, 20, 39, 68, 109, 164, 234};

    cic_interp_var #(
        .IN_WIDTH(16),
        .OUT_WIDTH(16),
        .STAGES(4),
        .DIFF_DELAY_LOG2(0),
        .MAX_RATE_LOG2(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_enable(clk_enable),
        .rate_log2(rate_log2),
        .bypass(bypass),
        .filter_in(filter_in),
        .filter_out(filter_out),
        .ce_out(ce_out)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic en, input logic signed [15:0] din);
        clk_enable = en;
        filter_in  = din;
        #1;
        last_ce = ce_out;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] rate);
        rate_log2 = rate;
        reset     = 1'b1;
        apply_stimulus(1'b1, 16'sd0);
        check_output("reset_ce", 32'(last_ce), 0);
        check_output("reset_out", filter_out, 0);
        reset = 1'b0;
    endtask

    // Checks one enable of the DC-1000, R=8 step response at enable index k.
    task automatic check_step(input string tag, input int k);
        check_output({tag, "_ce"}, 32'(last_ce), 32'((k % 8) == 7));
        if (k < 13) begin
            check_output({tag, "_out"}, filter_out, step_exp[k]);
        end else if (k >= 40) begin
            check_output({tag, "_settled"}, filter_out, 1000);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ecount;
        reset      = 1'b1;
        clk_enable = 1'b0;
        bypass     = 1'b0;
        rate_log2  = 3'd3;
        filter_in  = '0;

        // DC settle at R=8, including latency and ce_out period.
        do_reset(3'd3);
        for (int i = 0; i < 64; i++) begin
            apply_stimulus(1'b1, 16'sd1000);
            check_step("dc", i);
        end

        // Stalls 1-0-0-1: output and phase freeze on low cycles.
        do_reset(3'd3);
        ecount = 0;
        for (int c = 0; ecount < 48; c++) begin
            if ((c % 4 == 0) || (c % 4 == 3)) begin
                apply_stimulus(1'b1, 16'sd1000);
                check_step("stall", ecount);
                ecount++;
            end else begin
                apply_stimulus(1'b0, 16'sd1000);
                check_output("stall_low_ce", 32'(last_ce), 0);
                if (ecount == 0) begin
                    check_output("stall_hold", filter_out, 0);
                end else if (ecount - 1 < 13) begin
                    check_output("stall_hold", filter_out, step_exp[ecount-1]);
                end else if (ecount - 1 >= 40) begin
                    check_output("stall_hold", filter_out, 1000);
                end
            end
        end

        // Reset mid-stream at what would be phase 7: ce_out suppressed, history discarded.
        do_reset(3'd3);
        for (int i = 0; i < 23; i++) begin
            apply_stimulus(1'b1, 16'sd1000);
        end
        reset = 1'b1;
        apply_stimulus(1'b1, 16'sd1000);
        check_output("midreset_ce", 32'(last_ce), 0);
        check_output("midreset_out", filter_out, 0);
        reset = 1'b0;
        for (int i = 0; i < 48; i++) begin
            apply_stimulus(1'b1, 16'sd1000);
            check_step("rerun", i);
        end

        // Impulse at R=2: kernel 1,4,6,4,1 scaled by 16384/8, with one stall inside.
        imp_tab[0]  = '{1'b1, 16'sd16384, 0,     1'b0};
        imp_tab[1]  = '{1'b1, 16'sd0,     0,     1'b1};
        imp_tab[2]  = '{1'b1, 16'sd0,     0,     1'b0};
        imp_tab[3]  = '{1'b1, 16'sd0,     0,     1'b1};
        imp_tab[4]  = '{1'b1, 16'sd0,     0,     1'b0};
        imp_tab[5]  = '{1'b1, 16'sd0,     2048,  1'b1};
        imp_tab[6]  = '{1'b1, 16'sd0,     8192,  1'b0};
        imp_tab[7]  = '{1'b0, 16'sd0,     8192,  1'b0};
        imp_tab[8]  = '{1'b1, 16'sd0,     12288, 1'b1};
        imp_tab[9]  = '{1'b1, 16'sd0,     8192,  1'b0};
        imp_tab[10] = '{1'b1, 16'sd0,     2048,  1'b1};
        imp_tab[11] = '{1'b1, 16'sd0,     0,     1'b0};
        imp_tab[12] = '{1'b1, 16'sd0,     0,     1'b1};
        do_reset(3'd1);
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(imp_tab[i].en, imp_tab[i].din);
            check_output($sformatf("imp_ce[%0d]", i), 32'(last_ce), 32'(imp_tab[i].exp_ce));
            check_output($sformatf("imp_out[%0d]", i), filter_out, imp_tab[i].exp_out);
        end

        // Full-scale DC at requested rate 7, which clamps to 16.
        do_reset(3'd7);
        for (int i = 0; i < 112; i++) begin
            apply_stimulus(1'b1, 16'sd32767);
            check_output("fs_ce", 32'(last_ce), 32'((i % 16) == 15));
            check_output("fs_rise_range", 32'((filter_out >= 0) && (filter_out <= 32767)), 1);
            if (i >= 80) begin
                check_output("fs_pos", filter_out, 32767);
            end
        end
        for (int i = 0; i < 112; i++) begin
            apply_stimulus(1'b1, -16'sd32768);
            if (i >= 80) begin
                check_output("fs_neg", filter_out, -32768);
            end
        end

        // Bypass ramp, one stall, then leave bypass and change rate 3 -> 2 mid-period.
        do_reset(3'd3);
        bypass = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 16'(i));
            check_output("byp_ce", 32'(last_ce), 1);
            check_output("byp_out", filter_out, i);
        end
        apply_stimulus(1'b0, 16'sd99);
        check_output("byp_stall_ce", 32'(last_ce), 0);
        check_output("byp_stall_out", filter_out, 9);
        bypass = 1'b0;
        for (int i = 0; i < 28; i++) begin
            if (i == 10) begin
                rate_log2 = 3'd2;
            end
            apply_stimulus(1'b1, 16'sd0);
            check_output($sformatf("ratechg_ce[%0d]", i), 32'(last_ce),
                         32'((i == 7) || (i == 15) || (i == 19) || (i == 23) || (i == 27)));
            check_output("ratechg_out", filter_out, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
